// File: rtl/rif_timer_pkg.sv
// Shared constants and types for the timer register bank: register indices,
// CTRL/STATUS field positions, the CTRL struct and byte-lane merge helper.
package rif_timer_pkg;

    localparam logic [2:0] REG_ID      = 3'd0;
    localparam logic [2:0] REG_SCRATCH = 3'd1;
    localparam logic [2:0] REG_CTRL    = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_CMP     = 3'd4;
    localparam logic [2:0] REG_CNT_LO  = 3'd5;
    localparam logic [2:0] REG_CNT_HI  = 3'd6;
    localparam logic [2:0] REG_CNT_CLR = 3'd7;

    localparam int CTRL_EN_BIT      = 0;
    localparam int CTRL_RELOAD_BIT  = 1;
    localparam int CTRL_IRQ_EN_BIT  = 2;
    localparam int CTRL_PRESC_LSB   = 8;
    localparam int STATUS_MATCH_BIT = 0;

    localparam logic [31:0] CMP_RESET = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [7:0] prescale;
        logic       irq_en;
        logic       auto_reload;
        logic       tmr_en;
    } ctrl_t;

    function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
        return {16'h0000, c.prescale, 5'b00000, c.irq_en, c.auto_reload, c.tmr_en};
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rif_timer_if.sv
// Register-interface bundle between the AHB-Lite adapter (master) and a rif slave.
interface rif_timer_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   rif_addr;
    logic                    rif_addr_valid;
    logic                    rif_wr_req;
    logic                    rif_rd_req;
    logic [DATA_WIDTH/8-1:0] rif_wstrb;
    logic [DATA_WIDTH-1:0]   rif_wdata;
    logic [DATA_WIDTH-1:0]   rif_rdata;

    modport master (
        output rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata,
        input  rif_rdata, rif_addr_valid
    );

    modport slave (
        input  rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata,
        output rif_rdata, rif_addr_valid
    );
endinterface

// File: rtl/rif_timer_core.sv
// Prescaled 64-bit free-running counter with compare match and optional
// auto-reload; clr zeroes counter and prescaler and wins over everything.
module rif_timer_core (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        en,
    input  logic        auto_reload,
    input  logic [7:0]  prescale,
    input  logic [31:0] cmp,
    input  logic        clr,
    output logic [63:0] count,
    output logic        match_pulse
);
    logic [7:0]  presc_r;
    logic [63:0] count_r;
    logic        tick_s;
    logic [63:0] next_count_s;

    assign tick_s       = en & (presc_r == prescale);
    assign next_count_s = count_r + 64'd1;
    assign match_pulse  = tick_s & ~clr & (next_count_s[31:0] == cmp);
    assign count        = count_r;

    // Prescaler: held at zero while disabled or cleared, wraps on each tick.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            presc_r <= 8'd0;
        end else if (clr || !en || tick_s) begin
            presc_r <= 8'd0;
        end else begin
            presc_r <= presc_r + 8'd1;
        end
    end

    // Counter: clear beats reload, reload beats normal increment.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            count_r <= 64'd0;
        end else if (clr) begin
            count_r <= 64'd0;
        end else if (match_pulse && auto_reload) begin
            count_r <= 64'd0;
        end else if (tick_s) begin
            count_r <= next_count_s;
        end else begin
            count_r <= count_r;
        end
    end
endmodule

// File: rtl/rif_timer_regbank.sv
// Timer register bank on the rif bus: decode, byte-enabled writes, W1C status,
// atomic CNT_HI snapshot on CNT_LO reads, and the level interrupt.
module rif_timer_regbank
    import rif_timer_pkg::*;
#(
    parameter int          ADDR_WIDTH = 12,
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h5449_4D31
) (
    input  logic      HCLK,
    input  logic      HRESETn,
    rif_timer_if.slave rif,
    output logic      irq
);
    if (DATA_WIDTH != 32) begin : g_width_check
        $fatal(1, "rif_timer_regbank: DATA_WIDTH must be 32");
    end

    logic        hit_s;
    logic [2:0]  idx_s;
    logic        wr_sel_s;
    logic        unused_addr_s;
    logic [31:0] rdata_s;

    logic [31:0] scratch_r;
    ctrl_t       ctrl_r;
    ctrl_t       ctrl_next_s;
    logic        status_r;
    logic [31:0] cmp_r;
    logic [31:0] cnt_hi_r;
    logic        irq_r;

    logic        ctrl_wr_s;
    logic        w1c_s;
    logic        clr_s;
    logic        core_en_s;
    logic [63:0] count_s;
    logic        match_pulse_s;

    assign hit_s         = (rif.rif_addr[ADDR_WIDTH-1:5] == {(ADDR_WIDTH-5){1'b0}});
    assign idx_s         = rif.rif_addr[4:2];
    assign unused_addr_s = ^rif.rif_addr[1:0];
    assign wr_sel_s      = rif.rif_wr_req & hit_s;
    assign ctrl_wr_s     = wr_sel_s & (idx_s == REG_CTRL);
    assign w1c_s         = wr_sel_s & (idx_s == REG_STATUS) & rif.rif_wstrb[0]
                           & rif.rif_wdata[STATUS_MATCH_BIT];
    assign clr_s         = wr_sel_s & (idx_s == REG_CNT_CLR) & rif.rif_wstrb[0]
                           & rif.rif_wdata[0];

    // Next CTRL value; the counter only runs when enabled both before and after
    // this edge so a disabling write takes no tick.
    always_comb begin
        ctrl_next_s             = ctrl_r;
        ctrl_next_s.tmr_en      = (ctrl_wr_s & rif.rif_wstrb[0]) ? rif.rif_wdata[CTRL_EN_BIT]     : ctrl_r.tmr_en;
        ctrl_next_s.auto_reload = (ctrl_wr_s & rif.rif_wstrb[0]) ? rif.rif_wdata[CTRL_RELOAD_BIT] : ctrl_r.auto_reload;
        ctrl_next_s.irq_en      = (ctrl_wr_s & rif.rif_wstrb[0]) ? rif.rif_wdata[CTRL_IRQ_EN_BIT] : ctrl_r.irq_en;
        ctrl_next_s.prescale    = (ctrl_wr_s & rif.rif_wstrb[1]) ? rif.rif_wdata[CTRL_PRESC_LSB +: 8] : ctrl_r.prescale;
        core_en_s               = ctrl_r.tmr_en & ctrl_next_s.tmr_en;
    end

    rif_timer_core u_core (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .en          (core_en_s),
        .auto_reload (ctrl_r.auto_reload),
        .prescale    (ctrl_r.prescale),
        .cmp         (cmp_r),
        .clr         (clr_s),
        .count       (count_s),
        .match_pulse (match_pulse_s)
    );

    // Software-visible registers; hardware match set wins over W1C.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            scratch_r <= 32'h0000_0000;
            ctrl_r    <= '{prescale: 8'd0, irq_en: 1'b0, auto_reload: 1'b0, tmr_en: 1'b0};
            status_r  <= 1'b0;
            cmp_r     <= CMP_RESET;
            cnt_hi_r  <= 32'h0000_0000;
            irq_r     <= 1'b0;
        end else begin
            ctrl_r   <= ctrl_next_s;
            status_r <= match_pulse_s | (status_r & ~w1c_s);
            irq_r    <= status_r & ctrl_r.irq_en;
            if (wr_sel_s && (idx_s == REG_SCRATCH)) begin
                scratch_r <= apply_wstrb(scratch_r, rif.rif_wdata, rif.rif_wstrb);
            end else begin
                scratch_r <= scratch_r;
            end
            if (wr_sel_s && (idx_s == REG_CMP)) begin
                cmp_r <= apply_wstrb(cmp_r, rif.rif_wdata, rif.rif_wstrb);
            end else begin
                cmp_r <= cmp_r;
            end
            if (rif.rif_rd_req && hit_s && (idx_s == REG_CNT_LO)) begin
                cnt_hi_r <= count_s[63:32];
            end else begin
                cnt_hi_r <= cnt_hi_r;
            end
        end
    end

    // Zero-latency read mux.
    always_comb begin
        rdata_s = 32'h0000_0000;
        if (hit_s) begin
            case (idx_s)
                REG_ID:      rdata_s = ID_VALUE;
                REG_SCRATCH: rdata_s = scratch_r;
                REG_CTRL:    rdata_s = ctrl_to_word(ctrl_r);
                REG_STATUS:  rdata_s = {31'h0000_0000, status_r};
                REG_CMP:     rdata_s = cmp_r;
                REG_CNT_LO:  rdata_s = count_s[31:0];
                REG_CNT_HI:  rdata_s = cnt_hi_r;
                default:     rdata_s = 32'h0000_0000;
            endcase
        end else begin
            rdata_s = 32'h0000_0000;
        end
    end

    assign rif.rif_rdata      = rdata_s;
    assign rif.rif_addr_valid = hit_s;
    assign irq                = irq_r;
endmodule

// File: tb/tb_rif_timer_regbank.sv
// Directed bench for rif_timer_regbank: register vector table followed by
// timed sequences for match/reload, W1C races, prescaling, clear and snapshot.
module tb_rif_timer_regbank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [31:0] ID = 32'h5449_4D31;

    rif_timer_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32)) bus ();

    rif_timer_regbank #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_VALUE(ID)) dut (
        .HCLK    (clk),
        .HRESETn (rst_n),
        .rif     (bus),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic        wr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_valid;
    } vec_t;

    vec_t vecs [24];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
        bus.rif_addr   = a;
        bus.rif_wdata  = d;
        bus.rif_wstrb  = s;
        bus.rif_wr_req = 1'b1;
        @(negedge clk);
        bus.rif_wr_req = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
        bus.rif_addr = a;
        #1;
        check(nm, bus.rif_rdata, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.rif_addr   = 12'h000;
        bus.rif_wr_req = 1'b0;
        bus.rif_rd_req = 1'b0;
        bus.rif_wstrb  = 4'h0;
        bus.rif_wdata  = 32'h0000_0000;

        vecs[0]  = '{12'h000, 1'b0, 4'h0, 32'h0000_0000, ID,            1'b1};
        vecs[1]  = '{12'h008, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[2]  = '{12'h010, 1'b0, 4'h0, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1};
        vecs[3]  = '{12'h020, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[4]  = '{12'h00C, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[5]  = '{12'h01C, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[6]  = '{12'h018, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[7]  = '{12'h004, 1'b1, 4'hF, 32'hA5A5_A5A5, 32'h0000_0000, 1'b1};
        vecs[8]  = '{12'h004, 1'b1, 4'h1, 32'h0000_0011, 32'hA5A5_A5A5, 1'b1};
        vecs[9]  = '{12'h004, 1'b0, 4'h0, 32'h0000_0000, 32'hA5A5_A511, 1'b1};
        vecs[10] = '{12'h006, 1'b1, 4'h2, 32'h0000_2200, 32'hA5A5_A511, 1'b1};
        vecs[11] = '{12'h004, 1'b0, 4'h0, 32'h0000_0000, 32'hA5A5_2211, 1'b1};
        vecs[12] = '{12'h008, 1'b1, 4'hF, 32'hFFFF_FFF8, 32'h0000_0000, 1'b1};
        vecs[13] = '{12'h008, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_FF00, 1'b1};
        vecs[14] = '{12'h008, 1'b1, 4'h2, 32'h0000_0000, 32'h0000_FF00, 1'b1};
        vecs[15] = '{12'h008, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[16] = '{12'h020, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[17] = '{12'h804, 1'b1, 4'hF, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[18] = '{12'h004, 1'b0, 4'h0, 32'h0000_0000, 32'hA5A5_2211, 1'b1};
        vecs[19] = '{12'h000, 1'b1, 4'hF, 32'h0000_0000, ID,            1'b1};
        vecs[20] = '{12'h000, 1'b0, 4'h0, 32'h0000_0000, ID,            1'b1};
        vecs[21] = '{12'h010, 1'b1, 4'h1, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
        vecs[22] = '{12'h010, 1'b0, 4'h0, 32'h0000_0000, 32'hFFFF_FF05, 1'b1};
        vecs[23] = '{12'h014, 1'b0, 4'h0, 32'h0000_0000, 32'h0000_0000, 1'b1};

        idle(2);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            bus.rif_addr   = vecs[i].addr;
            bus.rif_wr_req = vecs[i].wr;
            bus.rif_wstrb  = vecs[i].wstrb;
            bus.rif_wdata  = vecs[i].wdata;
            #1;
            check($sformatf("vec%0d_rdata", i), bus.rif_rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_valid", i), {31'b0, bus.rif_addr_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d_irq", i), {31'b0, irq}, 32'h0000_0000);
            @(negedge clk);
            bus.rif_wr_req = 1'b0;
        end

        // Match with auto-reload and interrupt.
        wr(12'h010, 32'h0000_0005, 4'hF);
        wr(12'h008, 32'h0000_0007, 4'hF);
        rd_chk("run_start", 12'h014, 32'h0000_0000);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            rd_chk($sformatf("run_cnt%0d", k), 12'h014, k);
            rd_chk($sformatf("run_status%0d", k), 12'h00C, 32'h0000_0000);
        end
        @(negedge clk);
        check("match_irq_lag", {31'b0, irq}, 32'h0000_0000);
        rd_chk("reload_cnt", 12'h014, 32'h0000_0000);
        rd_chk("match_status", 12'h00C, 32'h0000_0001);
        @(negedge clk);
        check("irq_set", {31'b0, irq}, 32'h0000_0001);
        rd_chk("after_reload_cnt", 12'h014, 32'h0000_0001);

        // W1C on the same edge as a fresh match, then W1C with no match.
        idle(3);
        rd_chk("pre_race_cnt", 12'h014, 32'h0000_0004);
        wr(12'h00C, 32'h0000_0001, 4'hF);
        rd_chk("race_status", 12'h00C, 32'h0000_0001);
        rd_chk("race_cnt", 12'h014, 32'h0000_0000);
        check("race_irq", {31'b0, irq}, 32'h0000_0001);
        wr(12'h00C, 32'h0000_0001, 4'hF);
        check("w1c_irq_hold", {31'b0, irq}, 32'h0000_0001);
        rd_chk("w1c_status", 12'h00C, 32'h0000_0000);
        @(negedge clk);
        check("w1c_irq_fall", {31'b0, irq}, 32'h0000_0000);

        // Disabling write takes no tick on its edge.
        wr(12'h008, 32'h0000_0006, 4'hF);
        rd_chk("disable_cnt", 12'h014, 32'h0000_0002);
        @(negedge clk);
        rd_chk("disabled_hold", 12'h014, 32'h0000_0002);
        wr(12'h01C, 32'h0000_0001, 4'hF);
        rd_chk("clr_cnt", 12'h014, 32'h0000_0000);
        rd_chk("clr_reads0", 12'h01C, 32'h0000_0000);

        // Prescale 3: one increment every 4 cycles; clear on a tick edge.
        wr(12'h008, 32'h0000_0301, 4'hF);
        rd_chk("presc_start", 12'h014, 32'h0000_0000);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            rd_chk($sformatf("presc_cyc%0d", k), 12'h014, k / 4);
        end
        idle(3);
        wr(12'h01C, 32'h0000_0001, 4'hF);
        rd_chk("clr_on_tick", 12'h014, 32'h0000_0000);
        idle(3);
        rd_chk("presc_restart_hold", 12'h014, 32'h0000_0000);
        @(negedge clk);
        rd_chk("presc_restart_tick", 12'h014, 32'h0000_0001);
        wr(12'h008, 32'h0000_0000, 4'hF);

        // 32-bit carry and atomic HI snapshot.
        wr(12'h010, 32'hFFFF_FFFF, 4'hF);
        force dut.u_core.count_r = 64'h0000_0000_FFFF_FFFE;
        #1;
        release dut.u_core.count_r;
        rd_chk("forced_lo", 12'h014, 32'hFFFF_FFFE);
        wr(12'h008, 32'h0000_0001, 4'hF);
        idle(4);
        wr(12'h008, 32'h0000_0000, 4'hF);
        rd_chk("wrap_lo", 12'h014, 32'h0000_0002);
        rd_chk("hi_stale", 12'h018, 32'h0000_0000);
        rd_chk("wrap_status", 12'h00C, 32'h0000_0001);
        @(negedge clk);
        bus.rif_addr   = 12'h014;
        bus.rif_rd_req = 1'b1;
        #1;
        check("snap_lo", bus.rif_rdata, 32'h0000_0002);
        @(negedge clk);
        bus.rif_rd_req = 1'b0;
        rd_chk("snap_hi", 12'h018, 32'h0000_0001);
        check("no_irq_when_disabled", {31'b0, irq}, 32'h0000_0000);

        // Asynchronous reset mid-count clears everything.
        wr(12'h008, 32'h0000_0005, 4'hF);
        idle(2);
        rst_n = 1'b0;
        #1;
        check("rst_irq", {31'b0, irq}, 32'h0000_0000);
        rd_chk("rst_ctrl", 12'h008, 32'h0000_0000);
        rd_chk("rst_cmp", 12'h010, 32'hFFFF_FFFF);
        rd_chk("rst_lo", 12'h014, 32'h0000_0000);
        rd_chk("rst_hi", 12'h018, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        rd_chk("post_rst_lo", 12'h014, 32'h0000_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/rif_timer_regbank.md
Name: rif_timer_regbank

Overview:
- Register-interface (rif) slave sitting directly downstream of the AHB-Lite adapter. It consumes its rif_addr/rif_wr_req/rif_rd_req/rif_wstrb/rif_wdata and returns rif_rdata and rif_addr_valid.
- Implements an ID, scratch, control, W1C status, compare and a prescaled 64-bit free-running timer with atomic hi/lo snapshot, plus a level interrupt.

Parameters:
- ADDR_WIDTH, 12: rif address width; only bits [4:2] decoded, upper bits must be 0 for a hit.
- DATA_WIDTH, 32: rif data width; elaboration $fatal if not 32.
- ID_VALUE, 32'h5449_4D31: constant returned by the ID register.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- rif_addr  in  ADDR_WIDTH  byte address (read: address phase; write: latched data-phase address)
- rif_addr_valid  out  1  combinational: rif_addr decodes to a mapped register
- rif_wr_req  in  1  write strobe, data valid same cycle
- rif_rd_req  in  1  read strobe, rdata consumed same cycle
- rif_wstrb  in  DATA_WIDTH/8  byte enables for writes
- rif_wdata  in  DATA_WIDTH  write data
- rif_rdata  out  DATA_WIDTH  combinational read data for rif_addr
- irq  out  1  registered interrupt, level

Behaviour:
- Clock HCLK; reset HRESETn, asynchronous, active-low. All flops reset; reset mid-operation aborts any count and clears every register. No synchronous reset beyond CNT_CLR.
- Register map (byte offset, addr[1:0] ignored):
  - 0x00 ID RO = ID_VALUE.
  - 0x04 SCRATCH RW, reset 0.
  - 0x08 CTRL RW, reset 0: [0] tmr_en, [1] auto_reload, [2] irq_en, [15:8] prescale; other bits RAZ/WI.
  - 0x0C STATUS W1C, reset 0: [0] match, sticky.
  - 0x10 CMP RW, reset 32'hFFFF_FFFF.
  - 0x14 CNT_LO RO: counter[31:0].
  - 0x18 CNT_HI RO: shadow of counter[63:32].
  - 0x1C CNT_CLR WO: write with bit0=1 clears counter and prescaler; reads 0.
  - Unmapped: rif_addr_valid=0, rif_rdata=0, writes ignored.
- Reads:
  - Zero latency. rif_rdata and rif_addr_valid are purely combinational from rif_addr and register state.
  - No side effects except one: rif_rd_req at 0x14 loads the CNT_HI shadow with counter[63:32] at that clock edge, giving an atomic 64-bit read via LO then HI.
- Writes:
  - Take effect at the posedge where rif_wr_req=1 and the address hits.
  - Per-byte update only where rif_wstrb[b]=1. W1C also honours wstrb.
- Prescaler:
  - 8-bit counter, held at 0 while tmr_en=0.
  - When tmr_en=1: tick when presc==CTRL.prescale, then presc<=0; otherwise presc++. prescale=0 gives a tick every cycle.
- Counter:
  - 64-bit, increments by 1 on tick, wraps silently at 2^64.
  - Match condition: tick and next_count[31:0]==CMP. Sets STATUS.match the following edge.
  - If auto_reload, the counter loads 0 instead of next_count on match.
- Priorities, same edge:
  - CNT_CLR beats tick/reload.
  - Hardware match set beats STATUS W1C (bit stays 1).
  - CTRL write that clears tmr_en also zeroes the prescaler that edge; no tick is taken.
- irq: registered, irq <= STATUS.match & CTRL.irq_en (one cycle after either changes). Reset 0.
- Reset values: rif_addr_valid/rif_rdata follow decode of reset state; irq=0.
- Simultaneous rif_rd_req and rif_wr_req (pipelined AHB): both serviced. Read decodes rif_addr as presented; the write uses its own addressed register.

Decomposition:
- Package rif_timer_pkg: register offset localparams, CTRL/STATUS bit-position constants, ctrl_t packed struct, CMP reset value.
- One sub-module rif_timer_core: prescaler + 64-bit counter + match/reload. Inputs en, auto_reload, prescale, cmp, clr. Outputs count, match_pulse.
- Decode, W1C and shadow logic stay in the top.

Test Plan:
- Reset, then read 0x00, 0x08, 0x10, 0x20 -> 32'h5449_4D31, 0, 32'hFFFF_FFFF, 0 with addr_valid=0 for 0x20; irq=0.
- Write 0x04 data 32'hA5A5_A5A5 wstrb 4'hF, then data 32'h0000_0011 wstrb 4'h1 -> read 32'hA5A5_A511.
- CMP=5, CTRL=32'h0000_0007 (prescale 0, en, reload, irq_en) -> counter 1..5; match sets STATUS=1 the following cycle; counter reloads to 0; irq=1 one cycle after STATUS.
- Write 0x0C=1 on the same edge as a fresh match -> STATUS stays 1. Write 0x0C=1 with no match -> STATUS=0, irq falls next cycle.
- CTRL prescale=3, en=1 -> counter increments exactly every 4 cycles. CNT_CLR=1 written on a tick edge -> counter reads 0.
- Force counter near 2^32 (CMP=32'hFFFF_FFFF, no reload, prescale 0) -> read LO=0x0000_0002, HI=1; HI shadow unchanged by further counting until next LO read.
